// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receive deframer.
// State encoding, data width and a constant-evaluable clog2 helper.
package serial_rx_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_rx_deframer_if.sv
// Byte output handshake of the deframer: valid/ready with an 8-bit payload.
// The deframer drives the master side, the consumer the slave side.
interface serial_rx_deframer_if;
  import serial_rx_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/serial_rx_baud_gen.sv
// Bit-period down-counter: load-HALF re-targets mid-bit, load-FULL starts the next bit,
// run counts down. tick marks the sample cycle (count reached zero while running).
module serial_rx_baud_gen
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_half,
  input  logic load_full,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = run && (cnt_q == '0);

  // A resync edge outranks the bit reload; the top never asserts both together.
  always_comb begin
    cnt_d = cnt_q;
    if (load_half) begin
      cnt_d = HALF;
    end else if (load_full) begin
      cnt_d = FULL;
    end else if (run) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_rx_deframer.sv
// UART-style 8N1 frame receiver with edge resync and a single-entry output register.
// Optional 8E1 framing with parity_err output when SERIAL_RX_PARITY_EN is defined.
module serial_rx_deframer
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_level,
  input  logic                 rx_edge,
  serial_rx_deframer_if.master out_if,
  output logic                 frame_err,
`ifdef SERIAL_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun,
  output logic                 busy
);

  rx_state_e         state_q, state_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_q, par_d;
  logic              parity_err_q, parity_err_d;
`endif

  logic in_frame;
  logic tick;
  logic load_half;
  logic byte_done;

  assign in_frame = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);

  // An edge landing on the sample cycle is ignored so the sample stays on schedule.
  assign load_half = rx_edge && (((state_q == IDLE) && !rx_level) || (in_frame && !tick));

  serial_rx_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_half (load_half),
    .load_full (tick),
    .run       (in_frame),
    .tick      (tick)
  );

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rx_edge && !rx_level) state_d = START;
      end
      START: begin
        if (tick) begin
          if (!rx_level) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_level, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = rx_level;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!rx_level) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else begin
            state_d   = IDLE;
            byte_done = 1'b1;
          end
`ifdef SERIAL_RX_PARITY_EN
          // Even parity: data bits plus parity bit must XOR to zero.
          if (^{shift_q, par_q}) begin
            parity_err_d = 1'b1;
            byte_done    = 1'b0;
          end
`endif
        end
      end
      BREAK: begin
        if (rx_level) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Single-entry holding register; a same-cycle read frees room for the new byte.
    if (byte_done) begin
      if (!valid_q || out_if.rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_if.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_idx_q    <= 3'd0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_if.rx_data  = data_q;
  assign out_if.rx_valid = valid_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
  assign busy            = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err      = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed-plus-random bench for serial_rx_deframer (8N1, 16 clk per bit).
// Expected bytes and pulse counts come from a frame-level model of the receiver.
module tb_serial_rx_deframer;

  localparam int CPB = 16;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic rx_level = 1'b1;
  logic rx_edge  = 1'b0;
  logic frame_err;
  logic overrun;
  logic busy;
`ifdef SERIAL_RX_PARITY_EN
  logic parity_err;
`endif

  serial_rx_deframer_if bus ();

  serial_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_level   (rx_level),
    .rx_edge    (rx_edge),
    .out_if     (bus),
    .frame_err  (frame_err),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation side, sampled on the falling edge.
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  int         busy_cnt = 0;
  int         rise_cyc = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
    if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.rx_valid;
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
  end

  // Frame-level reference model of the consumer-visible behaviour.
  logic       m_held = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         exp_fe = 0;
  int         exp_ov = 0;
  logic [7:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b);
    if (bus.rx_ready) begin
      exp_q.push_back(b);
    end else if (!m_held) begin
      m_held = 1'b1;
      m_data = b;
    end else begin
      exp_ov++;
    end
  endtask

  task automatic model_ready_on();
    if (m_held) exp_q.push_back(m_data);
    m_held = 1'b0;
  endtask

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
  endtask

  // One clock of line activity; the edge strobe accompanies a level change.
  task automatic tick_line(input logic v);
    @(posedge clk);
    #2;
    rx_edge  = (v != rx_level);
    rx_level = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_line(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int blen,
                            input int max_cyc, output int sc);
    logic [9:0] bits;
    int n;
    bits = {stop, b, 1'b0};
    sc = -1;
    n = 0;
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < blen; k++) begin
        if (n < max_cyc) begin
          tick_line(bits[j]);
          if (n == 0) sc = cyc;
          n++;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sc;
    int         bc0;
    int         q0;
    logic [7:0] b;

    bus.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", {31'h0, bus.rx_valid}, 32'h0);
    check("rst_data", {24'h0, bus.rx_data}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    idle(5);

    // 1: clean frames with the consumer always ready; 0xA5 then random bytes.
    for (int f = 0; f < 4; f++) begin
      b = (f == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      rise_cyc = -1;
      bc0 = busy_cnt;
      send_frame(b, 1'b1, CPB, 10 * CPB, sc);
      idle(4);
      model_byte(b);
      check("t1_valid_latency", rise_cyc, sc + 9 * CPB + CPB / 2 + 1);
      check("t1_busy_cycles", busy_cnt - bc0, 9 * CPB + CPB / 2);
      $display("t1 frame %0d byte=%02h start=%0d rise=%0d", f, b, sc, rise_cyc);
    end
    compare_queues("t1");
    check("t1_frame_err", fe_cnt, exp_fe);
    check("t1_overrun", ov_cnt, exp_ov);

    // 2: two frames while the consumer stalls; second byte overruns.
    bus.rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, CPB, 10 * CPB, sc);
    model_byte(8'h3C);
    idle(2);
    send_frame(8'hC3, 1'b1, CPB, 10 * CPB, sc);
    model_byte(8'hC3);
    idle(4);
    check("t2_valid_held", {31'h0, bus.rx_valid}, {31'h0, m_held});
    check("t2_data_held", {24'h0, bus.rx_data}, {24'h0, m_data});
    check("t2_overrun", ov_cnt, exp_ov);
    $display("t2 held=%02h overruns=%0d", bus.rx_data, ov_cnt);
    bus.rx_ready = 1'b1;
    model_ready_on();
    idle(3);
    compare_queues("t2");
    check("t2_valid_drained", {31'h0, bus.rx_valid}, 32'h0);

    // 3: stop bit low followed by a held-low line.
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b0, CPB, 10 * CPB, sc);
    for (int i = 0; i < 40; i++) tick_line(1'b0);
    exp_fe++;
    check("t3_frame_err", fe_cnt, exp_fe);
    check("t3_busy_in_break", {31'h0, busy}, 32'h1);
    check("t3_no_byte", got_q.size(), 0);
    idle(4);
    check("t3_busy_released", {31'h0, busy}, 32'h0);
    $display("t3 byte=%02h frame_errs=%0d", b, fe_cnt);

    // 4: short low glitch from idle is a false start.
    bc0 = busy_cnt;
    for (int i = 0; i < 5; i++) tick_line(1'b0);
    idle(20);
    check("t4_busy_cycles", busy_cnt - bc0, CPB / 2 + 5);
    check("t4_busy", {31'h0, busy}, 32'h0);
    check("t4_no_byte", got_q.size(), 0);
    check("t4_frame_err", fe_cnt, exp_fe);
    check("t4_overrun", ov_cnt, exp_ov);
    $display("t4 glitch busy_cycles=%0d", busy_cnt - bc0);

    // 5: slow sender, 18 clk per bit, resynced on every edge.
    send_frame(8'h55, 1'b1, 18, 10 * 18, sc);
    idle(4);
    model_byte(8'h55);
    compare_queues("t5");
    check("t5_frame_err", fe_cnt, exp_fe);
    $display("t5 slow frame 55 start=%0d", sc);

    // 6: reset in the middle of a frame while a byte is held.
    bus.rx_ready = 1'b0;
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, CPB, 10 * CPB, sc);
    model_byte(b);
    idle(4);
    check("t6_held_before_rst", {31'h0, bus.rx_valid}, {31'h0, m_held});
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, CPB, 5 * CPB + CPB / 2, sc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_held = 1'b0;
    check("t6_rst_valid", {31'h0, bus.rx_valid}, 32'h0);
    check("t6_rst_data", {24'h0, bus.rx_data}, 32'h0);
    check("t6_rst_busy", {31'h0, busy}, 32'h0);
    tick_line(1'b1);
    tick_line(1'b1);
    rst_n = 1'b1;
    idle(5);
    bus.rx_ready = 1'b1;
    send_frame(8'h81, 1'b1, CPB, 10 * CPB, sc);
    idle(4);
    model_byte(8'h81);
    compare_queues("t6");
    check("t6_frame_err", fe_cnt, exp_fe);
    check("t6_overrun", ov_cnt, exp_ov);
    $display("t6 post-reset frame 81 start=%0d", sc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
